matrix_stream_loader: RTL and testbench
=======================================

Name: matrix_stream_loader

Overview:
- Upstream feeder for port 1 of the four-port data memory in the multicore matrix-multiply design.
- Receives a framed byte stream from the host-side receiver and assembles big-endian 16-bit words.
- Issues single-cycle write strobes (data, address, write enable) that fill operand matrices at a host-chosen base address before the cores start.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_WIDTH, 16, memory address width; matches the memory port.
- DATA_WIDTH, 16, memory word width; fixed at two bytes, and any other value is illegal.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle. Single-cycle qualifier; back-to-back bytes every cycle are legal.
- mem_data_in  out  16  write data to memory port 1.
- mem_addr  out  16  write address to memory port 1.
- mem_we  out  1  write enable, one cycle per word.
- busy  out  1  high from accepted sync byte until done.
- done  out  1  one-cycle pulse at frame end.
- sync_err  out  1  one-cycle pulse when a non-sync byte arrives in IDLE.
- words_loaded  out  16  count of words written in the current or last frame.

Behaviour:
- Reset (async, any state): state=IDLE. mem_data_in=0, mem_addr=0, mem_we=0, busy=0, done=0, sync_err=0, words_loaded=0. Any partial frame is discarded.
- Frame format, all multi-byte fields MSB first: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words, each sent as HI then LO byte.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, FINISH. A state advances only on rx_valid=1, except FINISH, which returns to IDLE unconditionally after one cycle.
- IDLE transitions:
  - rx_data==SYNC_BYTE: go to ADDR_HI, busy<=1, words_loaded<=0.
  - Any other byte: stay in IDLE, sync_err pulses for one cycle (registered, next cycle).
- CNT_LO transitions:
  - Count==0: go to FINISH (no writes).
  - Otherwise: go to DATA_HI and load an internal word index = 0.
- DATA_HI: latch the high byte, then go to DATA_LO.
- DATA_LO write (on its rx_valid):
  - All outputs are registered; on the next cycle mem_we=1, mem_data_in={hi,lo}, mem_addr=base+index (mod 2^ADDR_WIDTH; wraps 16'hFFFF -> 16'h0000 silently).
  - index and words_loaded increment.
  - If index+1==count, go to FINISH; otherwise return to DATA_HI.
- Timing: write latency is exactly 1 cycle after the LO byte's rx_valid. mem_we is never high for two consecutive cycles, because each word needs two bytes.
- Output holding: mem_addr and mem_data_in hold their last values when mem_we=0.
- FINISH: done=1 for one cycle and busy<=0 in the same cycle. done follows the last write by exactly 1 cycle. For count==0, done is asserted the cycle after the CNT_LO byte is accepted.
- A byte arriving during FINISH is ignored and not counted. The host must leave a gap of at least one cycle between frames.
- There is no timeout: a stalled frame holds busy until more bytes arrive or rst is asserted.
- SYNC_BYTE value appearing mid-frame is treated as ordinary data.
- words_loaded holds its value after done until the next accepted SYNC.

Decomposition:
- Shared package (matrix_pkg): SYNC_BYTE constant, ADDR_WIDTH/DATA_WIDTH constants, and the loader state enum, so the result-unloader can reuse the framing.
- Sub-module byte_pair_assembler: latches HI, emits a word plus valid on LO. It is small but is reused by the unloader's reverse path. The FSM and address counter stay in the top module.

Test Plan:
- Basic load: A5,00,0A,00,02,12,34,56,78 -> mem_we at addr 10 data 16'h1234, then addr 11 data 16'h5678. done one cycle after the second write, words_loaded=2, busy low after.
- Zero count: A5,00,20,00,00 -> no mem_we. done the cycle after the CNT_LO byte; busy high for exactly the header duration.
- Sync error: bytes 3C then A5,... -> sync_err pulse for the 3C byte, no state change. The following frame loads normally.
- Address wrap: A5,FF,FF,00,02,00,01,00,02 -> writes addr 16'hFFFF data 1, then addr 16'h0000 data 2.
- Reset mid-frame: assert rst after the DATA_HI byte of word 2 in a 4-word frame -> all outputs 0 immediately. No further writes; the next full frame loads correctly from index 0.
- Back-to-back bytes with gaps: the basic-load stream sent with rx_valid every cycle, then with random idle gaps -> identical write sequence and 1-cycle write latency in both cases.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: framing constants and loader state encoding shared by the
// matrix stream loader and the result unloader.
//   SYNC_BYTE      frame start marker
//   ADDR_WIDTH     data memory address width
//   DATA_WIDTH     data memory word width (two bytes, big-endian on the wire)
//   loader_state_t byte-framing FSM states
package matrix_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         ADDR_WIDTH = 16;
  localparam int         DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_CNT_HI  = 3'd3,
    ST_CNT_LO  = 3'd4,
    ST_DATA_HI = 3'd5,
    ST_DATA_LO = 3'd6,
    ST_FINISH  = 3'd7
  } loader_state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// byte_pair_assembler: joins two consecutive bytes into one big-endian word.
//   clk, rst    clock, async active-high reset
//   byte_in     incoming byte
//   hi_valid    byte_in is the high byte; it is latched
//   lo_valid    byte_in is the low byte; word is {latched hi, byte_in}
//   word        assembled word (combinational on the low byte)
//   word_valid  word is complete this cycle
module byte_pair_assembler
  import matrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  hi_valid,
  input  logic                  lo_valid,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 8'h00;
    end else if (hi_valid) begin
      hi_q <= byte_in;
    end
  end

  assign word       = {hi_q, byte_in};
  assign word_valid = lo_valid;

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: parses a framed host byte stream
//   SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words (HI, LO)
// and writes the words to consecutive addresses of data memory port 1.
//   clk, rst      clock, async active-high reset
//   rx_data       received byte
//   rx_valid      rx_data qualifier
//   mem_data_in   write data (held while mem_we is low)
//   mem_addr      write address (held while mem_we is low)
//   mem_we        one-cycle write strobe per word
//   busy          frame in progress (accepted sync until done)
//   done          one-cycle pulse at frame end
//   sync_err      one-cycle pulse for a non-sync byte while idle
//   words_loaded  words written in the current or last frame
//   state_dbg     current FSM state (loader_state_t encoding)
//
// Handshake: rx_valid is a single-cycle qualifier with no ready; a byte is
// consumed on every clock edge where rx_valid is high, except during the
// one-cycle FINISH state where it is dropped. Bytes may arrive every cycle.
module matrix_stream_loader #(
  parameter logic [7:0] SYNC_BYTE  = matrix_pkg::SYNC_BYTE,
  parameter int         ADDR_WIDTH = matrix_pkg::ADDR_WIDTH,
  parameter int         DATA_WIDTH = matrix_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  sync_err,
  output logic [15:0]           words_loaded,
  output logic [2:0]            state_dbg
);

  import matrix_pkg::*;

  // Words are always exactly two bytes on the wire.
  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("matrix_stream_loader: DATA_WIDTH must be 16");
  end

  loader_state_t state;
  logic [15:0]   base_q;
  logic [15:0]   count_q;
  logic [15:0]   index_q;
  logic [15:0]   addr_sum;

  logic [DATA_WIDTH-1:0] asm_word;
  logic                  asm_valid;

  byte_pair_assembler u_pair (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (rx_data),
    .hi_valid   (rx_valid && (state == ST_DATA_HI)),
    .lo_valid   (rx_valid && (state == ST_DATA_LO)),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Address arithmetic wraps modulo 2^16 with no indication.
  assign addr_sum  = base_q + index_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      index_q      <= '0;
      mem_data_in  <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sync_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Pulse outputs default low; address/data hold their last write.
      mem_we   <= 1'b0;
      done     <= 1'b0;
      sync_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == SYNC_BYTE) begin
              state        <= ST_ADDR_HI;
              busy         <= 1'b1;
              words_loaded <= '0;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        ST_ADDR_HI: if (rx_valid) begin
          base_q[15:8] <= rx_data;
          state        <= ST_ADDR_LO;
        end
        ST_ADDR_LO: if (rx_valid) begin
          base_q[7:0] <= rx_data;
          state       <= ST_CNT_HI;
        end
        ST_CNT_HI: if (rx_valid) begin
          count_q[15:8] <= rx_data;
          state         <= ST_CNT_LO;
        end
        ST_CNT_LO: if (rx_valid) begin
          count_q[7:0] <= rx_data;
          index_q      <= '0;
          if ({count_q[15:8], rx_data} == 16'd0) begin
            state <= ST_FINISH;
          end else begin
            state <= ST_DATA_HI;
          end
        end
        ST_DATA_HI: if (rx_valid) begin
          state <= ST_DATA_LO;
        end
        ST_DATA_LO: if (asm_valid) begin
          mem_we       <= 1'b1;
          mem_data_in  <= asm_word;
          mem_addr     <= addr_sum[ADDR_WIDTH-1:0];
          index_q      <= index_q + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          if (index_q + 16'd1 == count_q) begin
            state <= ST_FINISH;
          end else begin
            state <= ST_DATA_HI;
          end
        end
        ST_FINISH: begin
          // Any byte arriving here is dropped.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader. Drivers issue framed byte streams and push
// the writes, done pulses and sync errors they imply (with the clock edge at
// which each must appear) into queues; a monitor on the falling edge pops and
// compares whatever the DUT presents.
module tb_matrix_stream_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] mem_data_in;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        sync_err;
  logic [15:0] words_loaded;
  logic [2:0]  state_dbg;

  matrix_stream_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .sync_err     (sync_err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset / cycle stamp ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];   // {edge, addr, data}
  logic [31:0] done_q[$];  // edge at which done must be visible
  logic [31:0] serr_q[$];  // edge at which sync_err must be visible
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_edge = 0;
  int          busy_cnt  = 0;
  logic [15:0] fw[0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_we;
  logic [15:0] hold_addr;
  logic [15:0] hold_data;
  logic [63:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_we   = 1'b0;
      hold_addr = 16'h0000;
      hold_data = 16'h0000;
    end else begin
      if (busy) busy_cnt++;
      if (mem_we) begin
        check("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {32'(cyc), mem_addr, mem_data_in}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write", {32'(cyc), mem_addr, mem_data_in}, e);
          hold_addr = e[31:16];
          hold_data = e[15:0];
        end
      end else begin
        check("hold_addr_data", {32'd0, mem_addr, mem_data_in}, {32'd0, hold_addr, hold_data});
      end
      prev_we = mem_we;
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(cyc), 64'd0);
        else check("done_timing", 64'(cyc), 64'(done_q.pop_front()));
      end
      if (sync_err) begin
        if (serr_q.size() == 0) check("unexpected_sync_err", 64'(cyc), 64'd0);
        else check("sync_err_timing", 64'(cyc), 64'(serr_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Presents one byte; it is consumed by the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    if (max_gap > 0) idle($urandom_range(0, max_gap));
    @(negedge clk);
    rx_data   = b;
    rx_valid  = 1'b1;
    last_edge = cyc + 1;
  endtask

  // Sends a frame from fw[]; stops right after word abort_at's HI byte when
  // abort_at >= 0.
  task automatic send_frame(input logic [15:0] base, input int cnt,
                            input int max_gap, input int abort_at);
    logic [15:0] c16;
    c16 = 16'(cnt);
    send_byte(8'hA5, 0);
    send_byte(base[15:8], max_gap);
    send_byte(base[7:0], max_gap);
    check("busy_in_header", {63'd0, busy}, 64'd1);
    send_byte(c16[15:8], max_gap);
    send_byte(c16[7:0], max_gap);
    if (cnt == 0) done_q.push_back(32'(last_edge + 1));
    for (int i = 0; i < cnt; i++) begin
      send_byte(fw[i][15:8], max_gap);
      if (i == abort_at) return;
      send_byte(fw[i][7:0], max_gap);
      exp_q.push_back({32'(last_edge), 16'(base + 16'(i)), fw[i]});
      if (i == cnt - 1) done_q.push_back(32'(last_edge + 1));
    end
    idle(1);
  endtask

  task automatic frame_end_checks(input string tag, input int cnt);
    idle(3);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(cnt));
    check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    check({tag, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_seen"}, 64'(done_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  junk;
    logic [15:0] base;
    int          cnt;

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_data_in, mem_addr, words_loaded, 13'd0, mem_we, busy, done},
          64'd0);
    check("reset_sync_err", {63'd0, sync_err}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Basic load, bytes every cycle, then with random gaps.
    fw[0] = 16'h1234; fw[1] = 16'h5678;
    send_frame(16'h000A, 2, 0, -1);
    frame_end_checks("basic_b2b", 2);
    send_frame(16'h000A, 2, 3, -1);
    frame_end_checks("basic_gaps", 2);

    // Zero count: header only, busy for the five header cycles.
    busy_cnt = 0;
    send_frame(16'h0020, 0, 0, -1);
    frame_end_checks("zero_cnt", 0);
    check("zero_cnt_busy_cycles", 64'(busy_cnt), 64'd5);

    // Sync error then a normal frame.
    send_byte(8'h3C, 0);
    serr_q.push_back(32'(last_edge));
    idle(2);
    check("sync_err_stays_idle", {63'd0, busy}, 64'd0);
    send_frame(16'h000A, 2, 0, -1);
    frame_end_checks("after_sync_err", 2);
    check("sync_err_seen", 64'(serr_q.size()), 64'd0);

    // Address wrap, with sync value appearing as data.
    fw[0] = 16'h0001; fw[1] = 16'hA5A5;
    send_frame(16'hFFFF, 2, 0, -1);
    frame_end_checks("wrap", 2);

    // Reset after word 2's HI byte of a 4-word frame.
    for (int i = 0; i < 4; i++) fw[i] = 16'($urandom);
    send_frame(16'h0100, 4, 0, 1);
    idle(1);
    rst = 1'b1;
    #1;
    check("midframe_reset_outputs",
          {mem_data_in, mem_addr, words_loaded, 13'd0, mem_we, busy, done}, 64'd0);
    check("midframe_reset_sync_err", {63'd0, sync_err}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("after_reset_no_writes", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) fw[i] = 16'($urandom);
    send_frame(16'h0200, 4, 0, -1);
    frame_end_checks("after_reset", 4);

    // Random frames with junk bytes and gaps.
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, 1);
        serr_q.push_back(32'(last_edge));
        idle(1);
      end
      base = 16'($urandom);
      if ($urandom_range(0, 3) == 0) base = 16'hFFFD;
      cnt  = $urandom_range(0, 6);
      for (int i = 0; i < cnt; i++) begin
        fw[i] = ($urandom_range(0, 4) == 0) ? 16'hA5A5 : 16'($urandom);
      end
      send_frame(base, cnt, 2, -1);
      frame_end_checks("random", cnt);
    end

    idle(5);
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_q_empty", 64'(done_q.size()), 64'd0);
    check("final_serr_q_empty", 64'(serr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
